// File: rtl/ledg_seq_pkg.sv
// Shared definitions for the green-LED pattern sequencer: register offsets,
// CTRL/STATUS bit positions and the sequencer state encoding.
package ledg_seq_pkg;

  // Word register offsets on the slave port
  localparam logic [2:0] REG_DATA     = 3'd0;
  localparam logic [2:0] REG_CTRL     = 3'd1;
  localparam logic [2:0] REG_DWELL    = 3'd2;
  localparam logic [2:0] REG_LENGTH   = 3'd3;
  localparam logic [2:0] REG_PAT_ADDR = 3'd4;
  localparam logic [2:0] REG_PAT_DATA = 3'd5;
  localparam logic [2:0] REG_STATUS   = 3'd6;

  // CTRL bit positions
  localparam int unsigned CTRL_RUN    = 0;
  localparam int unsigned CTRL_LOOP   = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

  // STATUS bit positions
  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_DONE    = 1;
  localparam int unsigned STAT_IDX_LSB = 8;
  localparam int unsigned STAT_IDX_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/ledg_pattern_sequencer_if.sv
// Avalon-MM slave bus bundle for the LED pattern sequencer.
//   address    : word register offset
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data
//   readdata   : read data, combinational from address
interface ledg_pattern_sequencer_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/ledg_pattern_ram.sv
// DEPTH x LED_W pattern table: one synchronous write port, two asynchronous
// read ports (sequencer fetch and host read-back).
//   clk            : write clock
//   we/waddr/wdata : write port
//   seq_addr       : sequencer fetch address -> seq_data_c
//   host_addr      : host read-back address  -> host_data_c
module ledg_pattern_ram #(
  parameter int unsigned LED_W = 9,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [LED_W-1:0] wdata,
  input  logic [AW-1:0]    seq_addr,
  output logic [LED_W-1:0] seq_data_c,
  input  logic [AW-1:0]    host_addr,
  output logic [LED_W-1:0] host_data_c
);

  logic [LED_W-1:0] mem [DEPTH];

  // Table contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign seq_data_c  = mem[seq_addr];
  assign host_data_c = mem[host_addr];

endmodule

// File: rtl/ledg_pattern_sequencer.sv
// Green-LED pattern sequencer: steps a software-loaded table onto out_port
// with a programmable dwell, one-shot or looping, plus direct DATA writes.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   out_port     : registered LED drive
//   irq          : registered level interrupt, done & irq_en
module ledg_pattern_sequencer
  import ledg_seq_pkg::*;
#(
  parameter int unsigned LED_W   = 9,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned DWELL_W = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  ledg_pattern_sequencer_if.slave  bus,
  output logic [LED_W-1:0]         out_port,
  output logic                     irq
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned LEN_W = IDX_W + 1;

  state_e             state_q, state_d;
  logic [LED_W-1:0]   out_q, out_d;
  logic               run_q, run_d;
  logic               loop_q, loop_d;
  logic               irq_en_q, irq_en_d;
  logic               done_q, done_d;
  logic               irq_q, irq_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [IDX_W-1:0]   pat_addr_q, pat_addr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic               wr_c;
  logic               pat_we_c;
  logic               last_c;
  logic [DWELL_W-1:0] dwell_eff_c;
  logic [IDX_W-1:0]   seq_addr_c;
  logic [LED_W-1:0]   seq_data_c;
  logic [LED_W-1:0]   host_data_c;

  assign wr_c        = bus.chipselect & ~bus.write_n;
  assign pat_we_c    = wr_c && (bus.address == REG_PAT_DATA);
  assign dwell_eff_c = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
  // len_q is always held in 1..DEPTH, so the subtraction cannot underflow
  assign last_c      = ({1'b0, idx_q} >= (len_q - LEN_W'(1)));
  // Fetch address: next entry while stepping, otherwise entry 0 (LOAD or wrap)
  assign seq_addr_c  = (state_q == ST_RUN && !last_c) ? idx_q + IDX_W'(1) : '0;

  ledg_pattern_ram #(
    .LED_W (LED_W),
    .DEPTH (DEPTH),
    .AW    (IDX_W)
  ) u_ram (
    .clk         (clk),
    .we          (pat_we_c),
    .waddr       (pat_addr_q),
    .wdata       (bus.writedata[LED_W-1:0]),
    .seq_addr    (seq_addr_c),
    .seq_data_c  (seq_data_c),
    .host_addr   (pat_addr_q),
    .host_data_c (host_data_c)
  );

  // Register writes, then sequencer stepping, then the stop override
  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    run_d      = run_q;
    loop_d     = loop_q;
    irq_en_d   = irq_en_q;
    done_d     = done_q;
    dwell_d    = dwell_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    pat_addr_d = pat_addr_q;
    idx_d      = idx_q;

    if (wr_c) begin
      case (bus.address)
        REG_DATA: begin
          if (state_q == ST_IDLE) out_d = bus.writedata[LED_W-1:0];
        end
        REG_CTRL: begin
          loop_d   = bus.writedata[CTRL_LOOP];
          irq_en_d = bus.writedata[CTRL_IRQ_EN];
          if (state_q == ST_IDLE && bus.writedata[CTRL_RUN]) begin
            run_d   = 1'b1;
            state_d = ST_LOAD;
          end
        end
        REG_DWELL:    dwell_d = bus.writedata[DWELL_W-1:0];
        REG_LENGTH: begin
          if (bus.writedata == '0)               len_d = LEN_W'(1);
          else if (bus.writedata > 32'(DEPTH))   len_d = LEN_W'(DEPTH);
          else                                   len_d = bus.writedata[LEN_W-1:0];
        end
        REG_PAT_ADDR: pat_addr_d = bus.writedata[IDX_W-1:0];
        REG_PAT_DATA: pat_addr_d = pat_addr_q + IDX_W'(1);
        REG_STATUS: begin
          if (bus.writedata[STAT_DONE]) done_d = 1'b0;
        end
        default: ;
      endcase
    end

    // Sequencer; placed after the STATUS clear so a done-set wins
    case (state_q)
      ST_LOAD: begin
        out_d   = seq_data_c;
        idx_d   = '0;
        cnt_d   = dwell_eff_c - DWELL_W'(1);
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          if (!last_c) begin
            idx_d = idx_q + IDX_W'(1);
            out_d = seq_data_c;
            cnt_d = dwell_eff_c - DWELL_W'(1);
          end else if (loop_q) begin
            idx_d = '0;
            out_d = seq_data_c;
            cnt_d = dwell_eff_c - DWELL_W'(1);
          end else begin
            done_d  = 1'b1;
            run_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      default: ;
    endcase

    // Software stop freezes everything in place
    if (wr_c && bus.address == REG_CTRL && !bus.writedata[CTRL_RUN]) begin
      run_d   = 1'b0;
      state_d = ST_IDLE;
      out_d   = out_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
    end
  end

  assign irq_d = done_d & irq_en_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      out_q      <= '0;
      run_q      <= 1'b0;
      loop_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      irq_q      <= 1'b0;
      dwell_q    <= DWELL_W'(1);
      cnt_q      <= '0;
      len_q      <= LEN_W'(DEPTH);
      pat_addr_q <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      run_q      <= run_d;
      loop_q     <= loop_d;
      irq_en_q   <= irq_en_d;
      done_q     <= done_d;
      irq_q      <= irq_d;
      dwell_q    <= dwell_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      pat_addr_q <= pat_addr_d;
      idx_q      <= idx_d;
    end
  end

  // Zero-wait-state read mux
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      REG_DATA:     bus.readdata = 32'(out_q);
      REG_CTRL: begin
        bus.readdata[CTRL_RUN]    = run_q;
        bus.readdata[CTRL_LOOP]   = loop_q;
        bus.readdata[CTRL_IRQ_EN] = irq_en_q;
      end
      REG_DWELL:    bus.readdata = 32'(dwell_q);
      REG_LENGTH:   bus.readdata = 32'(len_q);
      REG_PAT_ADDR: bus.readdata = 32'(pat_addr_q);
      REG_PAT_DATA: bus.readdata = 32'(host_data_c);
      REG_STATUS: begin
        bus.readdata[STAT_BUSY] = (state_q != ST_IDLE);
        bus.readdata[STAT_DONE] = done_q;
        bus.readdata[STAT_IDX_LSB +: STAT_IDX_W] = STAT_IDX_W'(idx_q);
      end
      default: ;
    endcase
  end

  assign out_port = out_q;
  assign irq      = irq_q;

endmodule
